serial_complement_gate: RTL and testbench
=========================================

# serial_complement_gate

Parametrised successor to the G-15 inverting gate and early bus. It ORs N early-bus sources and passes the serial word through a mode-selected sign/complement gate onto the intermediate bus: pass, sign-magnitude to two's-complement, negate, or absolute value. Words are single or double length. It also checks word framing, reports minus-zero words and keeps a sticky overflow flag. It sits between the early-bus source selectors and the adder/line-write path.

## Interface
Parameters:
- N_SRC, 32, number of early-bus source lines.
- WORD_BITS, 29, bit times per word (sign plus magnitude), ≥ 3.

Ports:
- CLOCK  in  1  bit-time clock.
- rst  in  1  reset; asynchronous, active-low.
- eb_src  in  N_SRC  early-bus source terms, LSB-first serial, sign bit at TS.
- ts  in  1  sign-time strobe, one cycle per word.
- tl  in  1  last-bit-time strobe.
- mode  in  2  eb_mode_t; sampled only at first-word ts.
- dbl  in  1  double-length line; sampled only at first-word ts.
- rc  in  1  synchronous clear of the gate state.
- ovf_ext  in  1  external overflow set (adder, circuit X).
- fo_clr  in  1  overflow-flag clear.
- eb  out  1  OR of eb_src (combinational).
- ib  out  1  intermediate bus (combinational from eb and state).
- fo  out  1  sticky overflow.
- mz  out  1  one-cycle minus-zero pulse.
- frm_err  out  1  one-cycle framing-error pulse.

## Operation
- **Registers.** m (latched mode), d (latched dbl), wd (word index 0/1), is (invert pending), ic (inverting), nz (magnitude one seen), sg (input sign), cnt (bit counter, $clog2(WORD_BITS) bits), fo.
- **Sign time.** st = ts & (wd==0 | ~d).
- **ib at st, by mode:**
  - PASS: eb.
  - COMP: eb.
  - NEG: ~eb.
  - ABS: 0.
- **is at st:**
  - COMP: is ← eb.
  - NEG: is ← ~eb.
  - PASS and ABS: is ← 0.
- **Also at st:** ic←0, nz←0, sg←eb, m←mode, d←dbl.
- **Magnitude bits** (every other cycle, including a second-word ts): ib = eb ^ ic. ic ← ic | (is & eb). The first one bit passes unchanged; all later bits are inverted. nz ← nz | eb.
- **Double length.** If d=1, tl with wd=0 sets wd←1. The gate state carries over to word 2. tl with wd=1 clears wd.
- **Minus zero.** mz pulses the cycle after the final tl (wd=1 if d, else wd=0) when sg=1 and nz=0, with the final bit's eb included in nz.
- **Framing.** cnt←0 on ts, else cnt+1, saturating at WORD_BITS-1.
- **Framing errors.** frm_err pulses the cycle after either:
  - tl with cnt≠WORD_BITS-1;
  - ts and tl asserted together.
- **Overflow.** fo set on ovf_ext | frm_err. Cleared by fo_clr. Set wins over clear in the same cycle.
- **rc.** Clears is, ic, wd, nz, sg and sets m=PASS. fo is unaffected. rc together with ts: rc wins; the sign bit is passed as PASS.
- **ts mid-word.** Restarts the word and counter. wd is unchanged. A premature ts while d & wd=0 is taken as a new first word.

## Timing
- Reset values:
  - Outputs: ib=eb (PASS), fo=0, mz=0, frm_err=0.
  - Registers: m=PASS, all other state 0.
- eb→ib: zero-cycle combinational.
- State updates on the rising CLOCK edge.
- mz and frm_err: one cycle after tl.
- Reset asserted mid-word: all state clears immediately; output is pass-through until the next ts.
- mode/dbl changes between ts pulses: no effect.

## Structure
- Package g15_eb_pkg:
  - typedef enum logic [1:0] eb_mode_t {EBM_PASS, EBM_COMP, EBM_NEG, EBM_ABS};
  - localparam G15_WORD_BITS = 29.
- One sub-module, eb_frame_counter: cnt, saturation and the framing check, parametrised by WORD_BITS.
- Flag registers are async-reset flops inside the top module; no sr_ff instances.

## Test plan
- COMP, single word, -5 (sign 1, magnitude LSB-first 1,0,1,0…0) -> ib: 1, 1,1,0,1,1,…1. mz=0, fo=0.
- NEG, +5 -> ib sign 1, magnitude 1,1,0,1,1…; NEG of -5 -> ib sign 0, magnitude 1,0,1,0…0.
- COMP, double length, -2^28, first magnitude one in word 2 -> word 1 magnitude all 0. In word 2, the second ts is not treated as a sign. The first one passes and the rest invert.
- COMP, -0 (sign 1, all magnitude 0) -> ib 1,0…0. mz pulses one cycle after tl. A +0 word gives no mz.
- tl at cnt=27 with WORD_BITS=29 -> frm_err pulse and fo=1. fo_clr together with ovf_ext=1 leaves fo=1. fo_clr alone gives fo=0.
- rst low mid-word in COMP after ic set -> ib follows eb immediately and fo=0. rc together with ts -> sign passed unchanged, m=PASS.

Source files
------------

// File: rtl/g15_eb_pkg.sv
// g15_eb_pkg: shared modes, word length and sign-gate helpers for the early-bus gate
package g15_eb_pkg;

  typedef enum logic [1:0] {EBM_PASS, EBM_COMP, EBM_NEG, EBM_ABS} eb_mode_t;

  localparam int G15_WORD_BITS = 29;

  // Value driven onto ib during the sign bit time
  function automatic logic sign_out(input eb_mode_t m, input logic eb);
    return (m == EBM_NEG) ? ~eb : (m == EBM_ABS) ? 1'b0 : eb;
  endfunction

  // Whether the magnitude that follows must be complemented
  function automatic logic inv_pending(input eb_mode_t m, input logic eb);
    return (m == EBM_COMP) ? eb : (m == EBM_NEG) ? ~eb : 1'b0;
  endfunction

  function automatic logic inverting(input eb_mode_t m);
    return (m == EBM_COMP) || (m == EBM_NEG);
  endfunction

endpackage

// File: rtl/eb_frame_counter.sv
// eb_frame_counter: bit-time counter within a word and tl framing check
module eb_frame_counter
  import g15_eb_pkg::*;
#(
  parameter int WORD_BITS = G15_WORD_BITS
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic ts_i,
  input  logic tl_i,
  output logic err_o
);

  localparam int CW = $clog2(WORD_BITS);
  localparam logic [CW-1:0] LAST = CW'(WORD_BITS - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // cnt_d is the index of the current bit time; tl must land on the last one
  always_comb begin
    cnt_d = ts_i ? '0 : (cnt_q == LAST) ? cnt_q : cnt_q + 1'b1;
    err_o = tl_i & (ts_i | (cnt_d != LAST));
  end

  // Bit counter register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end

endmodule

// File: rtl/serial_complement_gate.sv
// serial_complement_gate: early-bus OR plus mode-selected serial sign/complement gate
module serial_complement_gate
  import g15_eb_pkg::*;
#(
  parameter int N_SRC     = 32,
  parameter int WORD_BITS = G15_WORD_BITS
) (
  input  logic             CLOCK,
  input  logic             rst,
  input  logic [N_SRC-1:0] eb_src,
  input  logic             ts,
  input  logic             tl,
  input  eb_mode_t         mode,
  input  logic             dbl,
  input  logic             rc,
  input  logic             ovf_ext,
  input  logic             fo_clr,
  output logic             eb,
  output logic             ib,
  output logic             fo,
  output logic             mz,
  output logic             frm_err
);

  eb_mode_t m_q, m_d;
  logic d_q, d_d, wd_q, wd_d, is_q, is_d, ic_q, ic_d, nz_q, nz_d, sg_q, sg_d;
  logic fo_q, fo_d, mz_q, mz_d, frm_err_q, frm_err_c;
  logic st, final_tl;

  eb_frame_counter #(.WORD_BITS(WORD_BITS)) u_frame (
    .clk_i (CLOCK),
    .rst_ni(rst),
    .ts_i  (ts),
    .tl_i  (tl),
    .err_o (frm_err_c)
  );

  assign eb       = |eb_src;
  assign st       = ts & (~wd_q | ~d_q);
  assign final_tl = tl & (d_q ? wd_q : ~wd_q);
  assign ib       = st ? (rc ? eb : sign_out(mode, eb)) : eb ^ ic_q;
  assign fo       = fo_q;
  assign mz       = mz_q;
  assign frm_err  = frm_err_q;

  // Gate next state: sign time latches mode/sign, magnitude bits track first one
  always_comb begin
    m_d  = m_q;
    d_d  = d_q;
    wd_d = wd_q;
    is_d = is_q;
    ic_d = ic_q;
    nz_d = nz_q;
    sg_d = sg_q;
    if (rc) begin
      m_d  = EBM_PASS;
      wd_d = 1'b0;
      is_d = 1'b0;
      ic_d = 1'b0;
      nz_d = 1'b0;
      sg_d = 1'b0;
    end else begin
      if (st) begin
        m_d  = mode;
        d_d  = dbl;
        is_d = inv_pending(mode, eb);
        ic_d = 1'b0;
        nz_d = 1'b0;
        sg_d = eb;
      end else begin
        ic_d = ic_q | (is_q & eb & inverting(m_q));
        nz_d = nz_q | eb;
      end
      if (tl) wd_d = d_q & ~wd_q;
    end
  end

  // Flag next state: set beats clear on fo
  always_comb begin
    mz_d = final_tl & sg_q & ~(nz_q | eb);
    fo_d = (ovf_ext | frm_err_q) ? 1'b1 : fo_clr ? 1'b0 : fo_q;
  end

  // Gate state registers
  always_ff @(posedge CLOCK or negedge rst) begin
    if (!rst) begin
      m_q  <= EBM_PASS;
      d_q  <= 1'b0;
      wd_q <= 1'b0;
      is_q <= 1'b0;
      ic_q <= 1'b0;
      nz_q <= 1'b0;
      sg_q <= 1'b0;
    end else begin
      m_q  <= m_d;
      d_q  <= d_d;
      wd_q <= wd_d;
      is_q <= is_d;
      ic_q <= ic_d;
      nz_q <= nz_d;
      sg_q <= sg_d;
    end
  end

  // Flag registers: minus-zero and framing pulses, sticky overflow
  always_ff @(posedge CLOCK or negedge rst) begin
    if (!rst) begin
      mz_q      <= 1'b0;
      frm_err_q <= 1'b0;
      fo_q      <= 1'b0;
    end else begin
      mz_q      <= mz_d;
      frm_err_q <= frm_err_c;
      fo_q      <= fo_d;
    end
  end

endmodule

// File: tb/tb_serial_complement_gate.sv
// tb_serial_complement_gate: directed vector bench for the early-bus sign/complement gate
module tb_serial_complement_gate;
  import g15_eb_pkg::*;

  localparam int N = 32;
  localparam int W = 29;

  logic CLOCK = 1'b0;
  logic rst = 1'b0;
  logic [N-1:0] eb_src = '0;
  logic ts = 1'b0, tl = 1'b0, dbl = 1'b0, rc = 1'b0, ovf_ext = 1'b0, fo_clr = 1'b0;
  eb_mode_t mode = EBM_PASS;
  logic eb, ib, fo, mz, frm_err;
  logic ib_s;
  logic [W-1:0] got;
  int checks = 0, errors = 0, sel = 0;

  typedef struct {
    string        nm;
    eb_mode_t     md;
    logic [W-1:0] in;
    logic [W-1:0] ib;
    logic         mz;
  } vec_t;

  vec_t tbl[14];

  always #5 CLOCK = ~CLOCK;

  serial_complement_gate #(.N_SRC(N), .WORD_BITS(W)) dut (
    .CLOCK(CLOCK), .rst(rst), .eb_src(eb_src), .ts(ts), .tl(tl), .mode(mode),
    .dbl(dbl), .rc(rc), .ovf_ext(ovf_ext), .fo_clr(fo_clr),
    .eb(eb), .ib(ib), .fo(fo), .mz(mz), .frm_err(frm_err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input logic t_s, input logic t_l, input logic e, input eb_mode_t md, input logic db);
    @(negedge CLOCK);
    ts   = t_s;
    tl   = t_l;
    mode = md;
    dbl  = db;
    sel  = (sel + 7) % N;
    eb_src = e ? ((N'(1) << sel) | (sel[0] ? (N'(1) << ((sel + 3) % N)) : '0)) : '0;
    #1 ib_s = ib;
    chk("eb_or", {31'b0, eb}, {31'b0, e});
    @(posedge CLOCK);
    #1;
  endtask

  task automatic run_word(input eb_mode_t md, input logic db, input logic [W-1:0] bits, output logic [W-1:0] g);
    for (int i = 0; i < W; i++) begin
      step(i == 0, i == W - 1, bits[i], (i == 0) ? md : eb_mode_t'(~md), (i == 0) ? db : ~db);
      g[i] = ib_s;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0]  = '{"comp_m5",   EBM_COMP, {28'd5, 1'b1},         {28'hFFFFFFB, 1'b1}, 1'b0};
    tbl[1]  = '{"neg_p5",    EBM_NEG,  {28'd5, 1'b0},         {28'hFFFFFFB, 1'b1}, 1'b0};
    tbl[2]  = '{"neg_m5",    EBM_NEG,  {28'd5, 1'b1},         {28'd5, 1'b0},       1'b0};
    tbl[3]  = '{"comp_m0",   EBM_COMP, {28'd0, 1'b1},         {28'd0, 1'b1},       1'b1};
    tbl[4]  = '{"comp_p0",   EBM_COMP, {28'd0, 1'b0},         {28'd0, 1'b0},       1'b0};
    tbl[5]  = '{"pass_m5",   EBM_PASS, {28'd5, 1'b1},         {28'd5, 1'b1},       1'b0};
    tbl[6]  = '{"abs_m5",    EBM_ABS,  {28'd5, 1'b1},         {28'd5, 1'b0},       1'b0};
    tbl[7]  = '{"comp_p5",   EBM_COMP, {28'd5, 1'b0},         {28'd5, 1'b0},       1'b0};
    tbl[8]  = '{"pass_m0",   EBM_PASS, {28'd0, 1'b1},         {28'd0, 1'b1},       1'b1};
    tbl[9]  = '{"comp_m6",   EBM_COMP, {28'd6, 1'b1},         {28'hFFFFFFA, 1'b1}, 1'b0};
    tbl[10] = '{"abs_m0",    EBM_ABS,  {28'd0, 1'b1},         {28'd0, 1'b0},       1'b1};
    tbl[11] = '{"comp_msb",  EBM_COMP, {28'h8000000, 1'b1},   {28'h8000000, 1'b1}, 1'b0};
    tbl[12] = '{"comp_ones", EBM_COMP, {28'hFFFFFFF, 1'b1},   {28'h0000001, 1'b1}, 1'b0};
    tbl[13] = '{"neg_m0",    EBM_NEG,  {28'd0, 1'b1},         {28'd0, 1'b0},       1'b1};
    eb_src = 32'h0001_0000;
    #3;
    chk("rst_eb", {31'b0, eb}, 32'd1);
    chk("rst_ib", {31'b0, ib}, 32'd1);
    chk("rst_fo", {31'b0, fo}, 32'd0);
    chk("rst_mz", {31'b0, mz}, 32'd0);
    chk("rst_frm", {31'b0, frm_err}, 32'd0);
    eb_src = '0;
    #1 chk("rst_ib0", {31'b0, ib}, 32'd0);
    @(negedge CLOCK);
    rst = 1'b1;
    for (int i = 0; i < 14; i++) begin
      run_word(tbl[i].md, 1'b0, tbl[i].in, got);
      chk({tbl[i].nm, "_ib"}, {3'b0, got}, {3'b0, tbl[i].ib});
      chk({tbl[i].nm, "_mz"}, {31'b0, mz}, {31'b0, tbl[i].mz});
      chk({tbl[i].nm, "_frm"}, {31'b0, frm_err}, 32'd0);
    end
    step(1'b0, 1'b0, 1'b0, EBM_PASS, 1'b0);
    chk("mz_one_cycle", {31'b0, mz}, 32'd0);
    // double length -2^28: first one at the second ts
    run_word(EBM_COMP, 1'b1, {28'd0, 1'b1}, got);
    chk("dbl_w1_ib", {3'b0, got}, {3'b0, 28'd0, 1'b1});
    chk("dbl_w1_mz", {31'b0, mz}, 32'd0);
    run_word(EBM_PASS, 1'b0, 29'd1, got);
    chk("dbl_w2_ib", {3'b0, got}, {3'b0, 29'h1FFFFFFF});
    chk("dbl_w2_mz", {31'b0, mz}, 32'd0);
    chk("dbl_w2_frm", {31'b0, frm_err}, 32'd0);
    // double length -0: mz only after the second word
    run_word(EBM_COMP, 1'b1, {28'd0, 1'b1}, got);
    chk("dblz_w1_ib", {3'b0, got}, {3'b0, 28'd0, 1'b1});
    chk("dblz_w1_mz", {31'b0, mz}, 32'd0);
    run_word(EBM_NEG, 1'b0, 29'd0, got);
    chk("dblz_w2_ib", {3'b0, got}, 32'd0);
    chk("dblz_w2_mz", {31'b0, mz}, 32'd1);
    // early tl at bit index 27
    for (int i = 0; i < W - 1; i++) step(i == 0, i == W - 2, 1'b0, EBM_PASS, 1'b0);
    chk("early_tl_frm", {31'b0, frm_err}, 32'd1);
    chk("early_tl_mz", {31'b0, mz}, 32'd0);
    step(1'b0, 1'b0, 1'b0, EBM_PASS, 1'b0);
    chk("early_tl_fo", {31'b0, fo}, 32'd1);
    chk("frm_one_cycle", {31'b0, frm_err}, 32'd0);
    step(1'b1, 1'b1, 1'b0, EBM_PASS, 1'b0);
    chk("ts_tl_frm", {31'b0, frm_err}, 32'd1);
    // async reset mid-word after ic set
    step(1'b1, 1'b0, 1'b1, EBM_COMP, 1'b0);
    step(1'b0, 1'b0, 1'b1, EBM_COMP, 1'b0);
    chk("mid_first_one", {31'b0, ib_s}, 32'd1);
    @(negedge CLOCK);
    ts = 1'b0;
    eb_src = '0;
    #1 chk("mid_inverted", {31'b0, ib}, 32'd1);
    chk("mid_fo_pre", {31'b0, fo}, 32'd1);
    rst = 1'b0;
    #1 chk("mid_rst_ib0", {31'b0, ib}, 32'd0);
    chk("mid_rst_fo", {31'b0, fo}, 32'd0);
    eb_src = 32'h8000_0000;
    #1 chk("mid_rst_ib1", {31'b0, ib}, 32'd1);
    @(negedge CLOCK);
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0, EBM_COMP, 1'b0);
    chk("post_rst_ib0", {31'b0, ib_s}, 32'd0);
    step(1'b0, 1'b0, 1'b1, EBM_COMP, 1'b0);
    chk("post_rst_ib1", {31'b0, ib_s}, 32'd1);
    // rc with ts: sign passed, magnitude not inverted
    rc = 1'b1;
    step(1'b1, 1'b0, 1'b0, EBM_NEG, 1'b0);
    chk("rc_ts_sign", {31'b0, ib_s}, 32'd0);
    rc = 1'b0;
    step(1'b0, 1'b0, 1'b1, EBM_NEG, 1'b0);
    chk("rc_mag1", {31'b0, ib_s}, 32'd1);
    step(1'b0, 1'b0, 1'b1, EBM_NEG, 1'b0);
    chk("rc_mag2", {31'b0, ib_s}, 32'd1);
    // sticky overflow: set beats clear
    ovf_ext = 1'b1;
    step(1'b0, 1'b0, 1'b0, EBM_PASS, 1'b0);
    chk("fo_set", {31'b0, fo}, 32'd1);
    fo_clr = 1'b1;
    step(1'b0, 1'b0, 1'b0, EBM_PASS, 1'b0);
    chk("fo_set_wins", {31'b0, fo}, 32'd1);
    ovf_ext = 1'b0;
    step(1'b0, 1'b0, 1'b0, EBM_PASS, 1'b0);
    chk("fo_clr", {31'b0, fo}, 32'd0);
    fo_clr = 1'b0;
    step(1'b0, 1'b0, 1'b0, EBM_PASS, 1'b0);
    chk("fo_stays_clr", {31'b0, fo}, 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
